// File: rtl/congestion_presel_agent.sv
// -----------------------------------------------------------------------------
// congestion_presel_agent
//
// Central congestion agent for an NX x NY adaptive mesh/torus NoC.
// Every cycle it takes the raw congestion value of every router, smooths
// each one with a per-node exponential moving average (EMA). From the smoothed
// values of each router's four neighbours it derives a registered 4-bit port
// preselection per router.
//
// Optional build macro: CONG_AGENT_HYST_EN
//   defined   : each presel bit flips only after the flip condition
//               (desired != current and |cX - cY| >= HYST_TH) has held
//               for HOLD_CYCLES consecutive unfrozen cycles.
//   undefined : no hold counters; each presel bit registers its desired
//               value every unfrozen cycle (a tie keeps the current value).
//
// Ports (NC = NX*NY, node i = y*NX + x, slice i = bits [(i+1)*w-1 : i*w]):
//   clk                in   1         clock
//   reset              in   1         synchronous, active-high reset
//   congestion_in_all  in   CONGw*NC  raw congestion per router
//   freeze             in   1         holds presel bits and hold counters;
//                                     the EMA keeps updating
//   port_presel_all    out  4*NC      per-router preselection, registered
//                                     bit0 NE, bit1 NW, bit2 SE, bit3 SW;
//                                     1 = prefer X port (E/W), 0 = prefer Y
//                                     port (N/S)
//
// Neighbours: N = y-1, S = y+1, E = x+1, W = x-1. TORUS wraps the indices;
// MESH treats a missing neighbour as maximally congested.
// -----------------------------------------------------------------------------
module congestion_presel_agent #(
  parameter int    NX          = 4,
  parameter int    NY          = 4,
  parameter string TOPOLOGY    = "MESH",
  parameter int    CONGw       = 2,
  parameter int    AVG_SHIFT   = 2,
  parameter int    HYST_TH     = 1,
  parameter int    HOLD_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CONGw*NX*NY-1:0]   congestion_in_all,
  input  logic                     freeze,
  output logic [4*NX*NY-1:0]       port_presel_all
);

  localparam int NC = NX * NY;
  // Accumulator holds the input scaled by 2^S, so it needs S extra bits.
  localparam int AW = CONGw + AVG_SHIFT;
  localparam bit IS_TORUS = (TOPOLOGY == "TORUS");
  localparam logic [CONGw-1:0] C_MAX = {CONGw{1'b1}};

  // Elaboration-time sanity check of the configuration.
  if (NX < 1 || NY < 1 || CONGw < 1 || AVG_SHIFT < 0 || AVG_SHIFT > 4 ||
      HOLD_CYCLES < 1 || HYST_TH < 0) begin : g_bad_params
    $error("congestion_presel_agent: parameter out of range");
  end

  // ---------------------------------------------------------------------------
  // EMA per node: acc <- acc - (acc >> S) + in, smoothed c = acc >> S.
  // The accumulator settles at in * 2^S, so it can never exceed
  // (2^CONGw - 1) * 2^S and no saturation logic is needed. With S = 0 the
  // update collapses to acc <- in.
  // ---------------------------------------------------------------------------
  logic [AW-1:0]    acc_q [NC];
  logic [CONGw-1:0] c_avg [NC];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (reset) begin
        acc_q[i] <= '0;
      end else begin
        acc_q[i] <= acc_q[i] - (acc_q[i] >> AVG_SHIFT)
                    + AW'(congestion_in_all[i*CONGw +: CONGw]);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      c_avg[i] = CONGw'(acc_q[i] >> AVG_SHIFT);
    end
  end

  // ---------------------------------------------------------------------------
  // Neighbour gathering. Per node, the four quadrant candidates are packed as
  // index 0 NE, 1 NW, 2 SE, 3 SW; cx_v holds the X-side value (E or W),
  // cy_v the Y-side value (N or S).
  // ---------------------------------------------------------------------------
  logic [3:0][CONGw-1:0] cx_v [NC];
  logic [3:0][CONGw-1:0] cy_v [NC];
  logic [3:0]            presel_q [NC];

  for (genvar gy = 0; gy < NY; gy++) begin : g_row
    for (genvar gx = 0; gx < NX; gx++) begin : g_col
      localparam int ID   = gy * NX + gx;
      localparam int ID_N = ((gy + NY - 1) % NY) * NX + gx;
      localparam int ID_S = ((gy + 1) % NY) * NX + gx;
      localparam int ID_E = gy * NX + ((gx + 1) % NX);
      localparam int ID_W = gy * NX + ((gx + NX - 1) % NX);
      localparam bit HAS_N = IS_TORUS || (gy > 0);
      localparam bit HAS_S = IS_TORUS || (gy < NY - 1);
      localparam bit HAS_E = IS_TORUS || (gx < NX - 1);
      localparam bit HAS_W = IS_TORUS || (gx > 0);

      logic [CONGw-1:0] cn, cs, ce, cw;

      assign cn = HAS_N ? c_avg[ID_N] : C_MAX;
      assign cs = HAS_S ? c_avg[ID_S] : C_MAX;
      assign ce = HAS_E ? c_avg[ID_E] : C_MAX;
      assign cw = HAS_W ? c_avg[ID_W] : C_MAX;

      //                  SW  SE  NW  NE
      assign cx_v[ID] = {cw, ce, cw, ce};
      assign cy_v[ID] = {cs, cs, cn, cn};

      assign port_presel_all[ID*4 +: 4] = presel_q[ID];
    end
  end

  // ---------------------------------------------------------------------------
  // Desired preference per quadrant: the less congested side wins, a tie
  // keeps whatever is currently registered.
  // ---------------------------------------------------------------------------
  logic [3:0] desired [NC];

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      desired[i] = presel_q[i];
      for (int q = 0; q < 4; q++) begin
        if (cx_v[i][q] < cy_v[i][q]) begin
          desired[i][q] = 1'b1;
        end else if (cy_v[i][q] < cx_v[i][q]) begin
          desired[i][q] = 1'b0;
        end
      end
    end
  end

`ifdef CONG_AGENT_HYST_EN
  // ---------------------------------------------------------------------------
  // Hysteresis: a bit flips only after its flip condition has been true for
  // HOLD_CYCLES consecutive unfrozen cycles. Any cycle without the condition
  // (including a tie, where desired == current) discards the partial count.
  // ---------------------------------------------------------------------------
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [3:0]       flip_req   [NC];
  logic [CNT_W-1:0] hold_cnt_q [NC][4];

  function automatic logic [CONGw-1:0] abs_diff(input logic [CONGw-1:0] a,
                                                input logic [CONGw-1:0] b);
    abs_diff = (a > b) ? (a - b) : (b - a);
  endfunction

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      for (int q = 0; q < 4; q++) begin
        flip_req[i][q] = (desired[i][q] != presel_q[i][q]) &&
                         (int'(abs_diff(cx_v[i][q], cy_v[i][q])) >= HYST_TH);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NC; i++) begin
        presel_q[i] <= '1;
        for (int q = 0; q < 4; q++) begin
          hold_cnt_q[i][q] <= '0;
        end
      end
    end else if (!freeze) begin
      for (int i = 0; i < NC; i++) begin
        for (int q = 0; q < 4; q++) begin
          if (flip_req[i][q]) begin
            if (hold_cnt_q[i][q] == CNT_LAST) begin
              presel_q[i][q]   <= desired[i][q];
              hold_cnt_q[i][q] <= '0;
            end else begin
              hold_cnt_q[i][q] <= hold_cnt_q[i][q] + 1'b1;
            end
          end else begin
            hold_cnt_q[i][q] <= '0;
          end
        end
      end
    end
  end
`else
  // ---------------------------------------------------------------------------
  // No hysteresis: every presel bit follows its desired value one cycle later.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NC; i++) begin
        presel_q[i] <= '1;
      end
    end else if (!freeze) begin
      for (int i = 0; i < NC; i++) begin
        presel_q[i] <= desired[i];
      end
    end
  end
`endif

endmodule
